// File: rtl/hsync_fifo.sv
// hsync_fifo: clocked multi-entry FIFO that accepts 4-phase bundled-data
// tokens on the input channel and re-issues them as 4-phase tokens on the
// output channel. r_i and a_o may come from unclocked logic and are
// synchronised into clk by SYNC flops (SYNC=0 means already synchronous).
// Optional feature: define HSYNC_FIFO_LEVEL_EN to expose the occupancy as
// `level` and the full flag as `full_o`.
module hsync_fifo #(
    parameter int   N        = 1,
    parameter int   DEPTH    = 4,
    parameter int   SYNC     = 2,
    parameter logic RdataVal = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r_i,
    output logic                   a_i,
    input  logic [N-1:0]           d_i,
    output logic                   r_o,
    input  logic                   a_o,
    output logic [N-1:0]           d_o
`ifdef HSYNC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full_o
`endif
);

    localparam int           AW       = $clog2(DEPTH);
    localparam int           CW       = AW + 1;
    localparam logic [N-1:0] RST_WORD = {N{RdataVal}};

    typedef enum logic       {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_SETUP, OUT_REQ, OUT_RTZ} out_state_t;

    logic          r_s, ao_s;
    in_state_t     in_state_q;
    out_state_t    out_state_q;
    logic          a_i_q, r_o_q;
    logic [N-1:0]  d_o_q;
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    generate
        if (SYNC == 0) begin : g_nosync
            assign r_s  = r_i;
            assign ao_s = a_o;
        end else begin : g_sync
            logic [SYNC-1:0] r_sync_q, a_sync_q;

            // Plain flop chains bringing the request/acknowledge into clk
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync_q <= '0;
                    a_sync_q <= '0;
                end else begin
                    r_sync_q[0] <= r_i;
                    a_sync_q[0] <= a_o;
                    for (int i = 1; i < SYNC; i++) begin
                        r_sync_q[i] <= r_sync_q[i-1];
                        a_sync_q[i] <= a_sync_q[i-1];
                    end
                end
            end

            assign r_s  = r_sync_q[SYNC-1];
            assign ao_s = a_sync_q[SYNC-1];
        end
    endgenerate

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO never acknowledges, so there is no overflow path at all.
    assign push  = (in_state_q == IN_IDLE) && r_s && !full;
    // The slot is only released on the observed acknowledge, never earlier.
    assign pop   = (out_state_q == OUT_REQ) && ao_s;

    // Occupancy next state; push and pop together cancel out
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Input-channel FSM: write on accepted request, hold a_i until r_s drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q <= IN_IDLE;
            a_i_q      <= 1'b0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_WORD;
        end else begin
            case (in_state_q)
                IN_IDLE: begin
                    if (push) begin
                        mem_q[wr_ptr_q] <= d_i;
                        wr_ptr_q        <= wr_ptr_q + AW'(1);
                        a_i_q           <= 1'b1;
                        in_state_q      <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!r_s) begin
                        a_i_q      <= 1'b0;
                        in_state_q <= IN_IDLE;
                    end
                end
                default: in_state_q <= IN_IDLE;
            endcase
        end
    end

    // Output-channel FSM: load d_o, give it a setup cycle, then raise r_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q <= OUT_IDLE;
            r_o_q       <= 1'b0;
            d_o_q       <= RST_WORD;
            rd_ptr_q    <= '0;
        end else begin
            case (out_state_q)
                OUT_IDLE: begin
                    // Waiting for ao_s low also covers a reset mid-handshake.
                    if (!empty && !ao_s) begin
                        d_o_q       <= mem_q[rd_ptr_q];
                        out_state_q <= OUT_SETUP;
                    end
                end
                OUT_SETUP: begin
                    r_o_q       <= 1'b1;
                    out_state_q <= OUT_REQ;
                end
                OUT_REQ: begin
                    if (ao_s) begin
                        rd_ptr_q    <= rd_ptr_q + AW'(1);
                        r_o_q       <= 1'b0;
                        out_state_q <= OUT_RTZ;
                    end
                end
                OUT_RTZ: begin
                    if (!ao_s) out_state_q <= OUT_IDLE;
                end
                default: out_state_q <= OUT_IDLE;
            endcase
        end
    end

    assign a_i = a_i_q;
    assign r_o = r_o_q;
    assign d_o = d_o_q;

`ifdef HSYNC_FIFO_LEVEL_EN
    assign level  = count_q;
    assign full_o = full;
`endif

endmodule
